// File: rtl/hack_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hack_mem_pkg
// Description : Shared constants and types for the Hack memory bank tree.
// Revision    : 1.0
// ============================================================================
package hack_mem_pkg;
    localparam int BANK_WORDS  = 4;
    localparam int BANK_ADDR_W = 2;

    // One-hot word-enable vector produced by the load demux.
    typedef logic [BANK_WORDS-1:0] word_en_t;
endpackage
`default_nettype wire

// File: rtl/DMux4Way.sv
`default_nettype none
// ============================================================================
// Module      : DMux4Way
// Description : Routes a single input to one of four outputs selected by sel.
// Revision    : 1.0
// ============================================================================
module DMux4Way (
    input  logic       in,
    input  logic [1:0] sel,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d
);
    assign a = in & (sel == 2'd0);
    assign b = in & (sel == 2'd1);
    assign c = in & (sel == 2'd2);
    assign d = in & (sel == 2'd3);
endmodule
`default_nettype wire

// File: rtl/ram4_bank_word.sv
`default_nettype none
// ============================================================================
// Module      : bank_word
// Description : WIDTH-bit storage register with load enable and reset value.
// Revision    : 1.0
// ============================================================================
module bank_word #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] word_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= RESET_VAL;
        end else if (load_i) begin
            word_q <= d_i;
        end
    end

    assign q_o = word_q;
endmodule
`default_nettype wire

// File: rtl/ram4_bank.sv
`default_nettype none
// ============================================================================
// Module      : ram4_bank
// Description : Four-word register bank with written flags and write counter.
// Revision    : 1.0
// ============================================================================
module ram4_bank
    import hack_mem_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in,
    input  logic [BANK_ADDR_W-1:0] address,
    input  logic                   load,
    output logic [WIDTH-1:0]       out,
    output logic [BANK_WORDS-1:0]  written,
    output logic [CNT_W-1:0]       wr_count
);
    word_en_t         word_en;
    logic [WIDTH-1:0] words [BANK_WORDS];

    logic [BANK_WORDS-1:0] written_q,  written_d;
    logic [CNT_W-1:0]      wr_count_q, wr_count_d;

    DMux4Way u_dmux (
        .in  (load),
        .sel (address),
        .a   (word_en[0]),
        .b   (word_en[1]),
        .c   (word_en[2]),
        .d   (word_en[3])
    );

    for (genvar g = 0; g < BANK_WORDS; g++) begin : g_word
        bank_word #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_word (
            .clk    (clk),
            .rst_n  (rst_n),
            .load_i (word_en[g]),
            .d_i    (in),
            .q_o    (words[g])
        );
    end

    // Read path is combinational; no bypass of the write data.
    assign out = words[address];

    always_comb begin
        written_d  = written_q | word_en;
        wr_count_d = wr_count_q;
        if (load && (wr_count_q != {CNT_W{1'b1}})) begin
            wr_count_d = wr_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            written_q  <= '0;
            wr_count_q <= '0;
        end else begin
            written_q  <= written_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign written  = written_q;
    assign wr_count = wr_count_q;

    a_addr_known: assert property (@(posedge clk) disable iff (!rst_n)
        load |-> !$isunknown(address));
endmodule
`default_nettype wire

// File: tb/tb_ram4_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram4_bank
// Description : Scoreboard bench for ram4_bank (default and narrow-counter builds).
// Revision    : 1.0
// ============================================================================
module tb_ram4_bank;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in = '0;
    logic [1:0]  address = '0;
    logic        load = 1'b0;

    logic [15:0] out_a, out_b;
    logic [3:0]  written_a, written_b;
    logic [7:0]  wr_count_a;
    logic [1:0]  wr_count_b;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] mem_a [4];
    logic [15:0] mem_b [4];
    logic [3:0]  m_written;
    int          m_cnt_a;
    int          m_cnt_b;

    logic [15:0] exp_q [$];

    ram4_bank dut_a (
        .clk(clk), .rst_n(rst_n), .in(in), .address(address), .load(load),
        .out(out_a), .written(written_a), .wr_count(wr_count_a)
    );

    ram4_bank #(.WIDTH(16), .RESET_VAL(16'hA5A5), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in(in), .address(address), .load(load),
        .out(out_b), .written(written_b), .wr_count(wr_count_b)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mem_a[i] = 16'h0000;
                mem_b[i] = 16'hA5A5;
            end
            m_written = 4'b0000;
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else if (load) begin
            mem_a[address] = in;
            mem_b[address] = in;
            m_written[address] = 1'b1;
            if (m_cnt_a < 255) m_cnt_a++;
            if (m_cnt_b < 3) m_cnt_b++;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] e;
        rst_n = 1'b0;
        load = 1'b0;
        step();
        rst_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            exp_q.push_back(16'h0000);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (out_a !== e) begin
                failures++;
                $display("FAIL reset_out addr=%0d got=%h exp=%h", a, out_a, e);
            end
        end
        checks++;
        if (written_a !== 4'b0000) begin
            failures++;
            $display("FAIL reset_written got=%b exp=0000", written_a);
        end
        checks++;
        if (wr_count_a !== 8'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", wr_count_a);
        end
    endtask

    task automatic test_write_all();
        logic [15:0] data [4];
        logic [15:0] e;
        data[0] = 16'h1111; data[1] = 16'h2222; data[2] = 16'h4444; data[3] = 16'h8888;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            in = data[a];
            load = 1'b1;
            step();
        end
        load = 1'b0;
        in = 16'h0000;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            exp_q.push_back(mem_a[a]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (out_a !== e) begin
                failures++;
                $display("FAIL write_all_out addr=%0d got=%h exp=%h", a, out_a, e);
            end
        end
        checks++;
        if (written_a !== 4'b1111) begin
            failures++;
            $display("FAIL write_all_written got=%b exp=1111", written_a);
        end
        checks++;
        if (wr_count_a !== 8'd4) begin
            failures++;
            $display("FAIL write_all_count got=%0d exp=4", wr_count_a);
        end
    endtask

    task automatic test_no_write_through();
        logic [15:0] e;
        address = 2'd2;
        in = 16'hBEEF;
        load = 1'b1;
        exp_q.push_back(16'h4444);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (out_a !== e) begin
            failures++;
            $display("FAIL nwt_during got=%h exp=%h", out_a, e);
        end
        step();
        load = 1'b0;
        exp_q.push_back(16'hBEEF);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (out_a !== e) begin
            failures++;
            $display("FAIL nwt_after got=%h exp=%h", out_a, e);
        end
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            exp_q.push_back(mem_a[a]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (out_a !== e) begin
                failures++;
                $display("FAIL nwt_others addr=%0d got=%h exp=%h", a, out_a, e);
            end
        end
    endtask

    task automatic test_hold();
        logic [15:0] e;
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in = 16'($urandom);
            address = 2'($urandom_range(0, 3));
            step();
        end
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            exp_q.push_back(mem_a[a]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (out_a !== e) begin
                failures++;
                $display("FAIL hold_out addr=%0d got=%h exp=%h", a, out_a, e);
            end
        end
        checks++;
        if (written_a !== m_written || wr_count_a !== 8'(m_cnt_a)) begin
            failures++;
            $display("FAIL hold_status got=%b/%0d exp=%b/%0d",
                     written_a, wr_count_a, m_written, m_cnt_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        address = 2'd1;
        load = 1'b1;
        in = 16'h1234;
        step();
        in = 16'h5678;
        step();
        load = 1'b0;
        exp_q.push_back(mem_a[1]);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (out_a !== e || e !== 16'h5678) begin
            failures++;
            $display("FAIL b2b_out got=%h exp=5678", out_a);
        end
        checks++;
        if (wr_count_a !== 8'(m_cnt_a)) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=%0d", wr_count_a, m_cnt_a);
        end
    endtask

    task automatic test_reset_priority();
        logic [15:0] e;
        rst_n = 1'b0;
        load = 1'b1;
        address = 2'd1;
        in = 16'hFFFF;
        step();
        rst_n = 1'b1;
        load = 1'b0;
        exp_q.push_back(16'h0000);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (out_a !== e) begin
            failures++;
            $display("FAIL rstpri_word1 got=%h exp=%h", out_a, e);
        end
        checks++;
        if (written_a !== 4'b0000 || wr_count_a !== 8'd0) begin
            failures++;
            $display("FAIL rstpri_status got=%b/%0d exp=0000/0", written_a, wr_count_a);
        end
    endtask

    task automatic test_saturation();
        int exp_seq [5];
        exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 3; exp_seq[3] = 3; exp_seq[4] = 3;
        for (int i = 0; i < 5; i++) begin
            address = 2'(i % 4);
            in = 16'(16'h0100 * (i + 1));
            load = 1'b1;
            step();
            checks++;
            if (wr_count_b !== 2'(exp_seq[i]) || m_cnt_b != exp_seq[i]) begin
                failures++;
                $display("FAIL sat_count write=%0d got=%0d exp=%0d", i + 1, wr_count_b, exp_seq[i]);
            end
        end
        load = 1'b0;
        checks++;
        if (wr_count_a !== 8'(m_cnt_a)) begin
            failures++;
            $display("FAIL sat_wide_count got=%0d exp=%0d", wr_count_a, m_cnt_a);
        end
    endtask

    task automatic test_reset_val();
        logic [15:0] e;
        rst_n = 1'b0;
        load = 1'b0;
        step();
        rst_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            exp_q.push_back(mem_b[a]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (out_b !== e || e !== 16'hA5A5) begin
                failures++;
                $display("FAIL resetval_out addr=%0d got=%h exp=a5a5", a, out_b);
            end
        end
        checks++;
        if (written_b !== 4'b0000 || wr_count_b !== 2'd0) begin
            failures++;
            $display("FAIL resetval_status got=%b/%0d exp=0000/0", written_b, wr_count_b);
        end
    endtask

    initial begin
        test_reset();
        test_write_all();
        test_no_write_through();
        test_hold();
        test_back_to_back();
        test_reset_priority();
        test_saturation();
        test_reset_val();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
